// File: rtl/char_mem_sequencer_if.sv
// Bus bundle between the host loader / render path and the character memory sequencer.
// The slave modport is the sequencer side; the master modport is the requester/array side.
interface char_mem_sequencer_if #(
  parameter int unsigned CHAR_COUNT = 36
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [19:0]           wr_pattern;
  logic                  wr_done;
  logic                  busy;
  logic                  rd_req;
  logic [1:0]            rd_x;
  logic [2:0]            rd_y;
  logic [5:0]            rd_char;
  logic                  rd_valid;
  logic                  rd_pixel;
  logic                  mem_write;
  logic [1:0]            mem_x;
  logic [2:0]            mem_y;
  logic                  mem_data_in;
  logic [CHAR_COUNT-1:0] mem_data_out;

  modport slave (
    input  wr_valid, wr_pattern, rd_req, rd_x, rd_y, rd_char, mem_data_out,
    output wr_ready, wr_done, busy, rd_valid, rd_pixel,
           mem_write, mem_x, mem_y, mem_data_in
  );

  modport master (
    output wr_valid, wr_pattern, rd_req, rd_x, rd_y, rd_char, mem_data_out,
    input  wr_ready, wr_done, busy, rd_valid, rd_pixel,
           mem_write, mem_x, mem_y, mem_data_in
  );
endinterface

// File: rtl/char_mem_sequencer.sv
// Arbitrates the glyph array x/y bus between render lookups (priority) and a
// serialized 20-bit host glyph load that stalls while render owns the bus.
module char_mem_sequencer #(
  parameter int unsigned CHAR_COUNT = 36,
  parameter int unsigned GLYPH_W    = 4,
  parameter int unsigned GLYPH_H    = 5
) (
  input  logic                  clock,
  input  logic                  rst,
  char_mem_sequencer_if.slave   bus
);
  localparam int unsigned NBITS    = GLYPH_W * GLYPH_H;
  localparam logic [4:0]  LAST_IDX = 5'(NBITS - 1);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t      state, state_next;
  logic [4:0]  idx;
  logic [19:0] pattern;
  logic [4:0]  bit_sel;
  logic        in_range;
  logic        rd_valid_q, rd_pixel_q;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.wr_valid) state_next = WRITE;
      WRITE:   if (!bus.rd_req && idx == LAST_IDX) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Counter only advances on cycles that actually wrote a bit.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      pattern <= '0;
    end else if (state == IDLE && bus.wr_valid) begin
      idx     <= '0;
      pattern <= bus.wr_pattern;
    end else if (state == WRITE && !bus.rd_req && idx != LAST_IDX) begin
      idx <= idx + 5'd1;
    end
  end

  assign bit_sel  = LAST_IDX - idx;
  assign in_range = (32'(bus.rd_char) < CHAR_COUNT) &&
                    (32'(bus.rd_x) < GLYPH_W) &&
                    (32'(bus.rd_y) < GLYPH_H);

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_pixel_q <= 1'b0;
    end else begin
      rd_valid_q <= bus.rd_req;
      if (bus.rd_req) rd_pixel_q <= in_range ? bus.mem_data_out[bus.rd_char] : 1'b0;
    end
  end

  always_comb begin
    bus.mem_write   = 1'b0;
    bus.mem_x       = '0;
    bus.mem_y       = '0;
    bus.mem_data_in = 1'b0;
    if (bus.rd_req) begin
      bus.mem_x = bus.rd_x;
      bus.mem_y = bus.rd_y;
    end else if (state == WRITE) begin
      bus.mem_write   = 1'b1;
      bus.mem_x       = 2'(32'(idx) % GLYPH_W);
      bus.mem_y       = 3'(32'(idx) / GLYPH_W);
      bus.mem_data_in = pattern[bit_sel];
    end
  end

  assign bus.wr_ready = (state == IDLE);
  assign bus.busy     = (state == WRITE);
  assign bus.wr_done  = (state == DONE);
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_pixel = rd_pixel_q;
endmodule

// File: tb/tb_char_mem_sequencer.sv
// Directed bench for char_mem_sequencer: render lookup table plus load,
// contention, reset-abort and back-to-back load sequences.
module tb_char_mem_sequencer;
  logic clock = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  char_mem_sequencer_if #(.CHAR_COUNT(36)) bus ();

  char_mem_sequencer #(.CHAR_COUNT(36), .GLYPH_W(4), .GLYPH_H(5)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rd_req;
    logic [1:0]  x;
    logic [2:0]  y;
    logic [5:0]  ch;
    logic [35:0] mdo;
    logic        e_valid;
    logic        e_pixel;
    logic [1:0]  e_mx;
    logic [2:0]  e_my;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic write_check(input int i, input logic [19:0] p);
    logic [19:0] pv;
    pv = p;
    chk($sformatf("wr%0d_we", i),   64'(bus.mem_write),   64'd1);
    chk($sformatf("wr%0d_x", i),    64'(bus.mem_x),       64'(i % 4));
    chk($sformatf("wr%0d_y", i),    64'(bus.mem_y),       64'(i / 4));
    chk($sformatf("wr%0d_d", i),    64'(bus.mem_data_in), 64'(pv[19-i]));
    chk($sformatf("wr%0d_busy", i), 64'(bus.busy),        64'd1);
    chk($sformatf("wr%0d_done", i), 64'(bus.wr_done),     64'd0);
  endtask

  task automatic idle_outputs_check(input string tag);
    chk({tag, "_rd_valid"}, 64'(bus.rd_valid),    64'd0);
    chk({tag, "_rd_pixel"}, 64'(bus.rd_pixel),    64'd0);
    chk({tag, "_wr_done"},  64'(bus.wr_done),     64'd0);
    chk({tag, "_busy"},     64'(bus.busy),        64'd0);
    chk({tag, "_mem_we"},   64'(bus.mem_write),   64'd0);
    chk({tag, "_mem_x"},    64'(bus.mem_x),       64'd0);
    chk({tag, "_mem_y"},    64'(bus.mem_y),       64'd0);
    chk({tag, "_mem_d"},    64'(bus.mem_data_in), 64'd0);
    chk({tag, "_wr_ready"}, 64'(bus.wr_ready),    64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] p;
    int          n;
    bit          seen;

    //        req x  y  ch  mdo                 valid pix mx my
    vt[0]  = '{1, 1, 2, 0,  36'h0_0000_0001,   1, 1,  1, 2};
    vt[1]  = '{1, 3, 4, 35, 36'h8_0000_0000,   1, 1,  3, 4};
    vt[2]  = '{1, 0, 0, 35, 36'h7_FFFF_FFFF,   1, 0,  0, 0};
    vt[3]  = '{0, 2, 3, 5,  36'hF_FFFF_FFFF,   0, 0,  0, 0};
    vt[4]  = '{1, 2, 3, 40, 36'hF_FFFF_FFFF,   1, 0,  2, 3};
    vt[5]  = '{1, 1, 6, 3,  36'hF_FFFF_FFFF,   1, 0,  1, 6};
    vt[6]  = '{1, 2, 1, 3,  36'hF_FFFF_FFFF,   1, 1,  2, 1};
    vt[7]  = '{0, 0, 0, 0,  36'h0_0000_0000,   0, 1,  0, 0};
    vt[8]  = '{1, 0, 0, 36, 36'hF_FFFF_FFFF,   1, 0,  0, 0};
    vt[9]  = '{1, 0, 5, 0,  36'hF_FFFF_FFFF,   1, 0,  0, 5};
    vt[10] = '{1, 3, 4, 0,  36'h0_0000_0001,   1, 1,  3, 4};

    rst = 1'b1;
    bus.wr_valid = 1'b0; bus.wr_pattern = '0;
    bus.rd_req = 1'b0; bus.rd_x = '0; bus.rd_y = '0; bus.rd_char = '0;
    bus.mem_data_out = '0;
    #2 idle_outputs_check("reset");
    @(negedge clock) rst = 1'b0;

    // Render lookups while idle
    for (int k = 0; k < 11; k++) begin
      @(negedge clock);
      bus.rd_req = vt[k].rd_req; bus.rd_x = vt[k].x; bus.rd_y = vt[k].y;
      bus.rd_char = vt[k].ch; bus.mem_data_out = vt[k].mdo;
      #2;
      chk($sformatf("v%0d_mem_x", k),  64'(bus.mem_x),     64'(vt[k].e_mx));
      chk($sformatf("v%0d_mem_y", k),  64'(bus.mem_y),     64'(vt[k].e_my));
      chk($sformatf("v%0d_mem_we", k), 64'(bus.mem_write), 64'd0);
      @(posedge clock); #2;
      chk($sformatf("v%0d_rd_valid", k), 64'(bus.rd_valid), 64'(vt[k].e_valid));
      chk($sformatf("v%0d_rd_pixel", k), 64'(bus.rd_pixel), 64'(vt[k].e_pixel));
    end
    @(negedge clock);
    bus.rd_req = 1'b0; bus.mem_data_out = '0;

    // Plain load
    @(negedge clock);
    p = 20'hA5A5A; bus.wr_valid = 1'b1; bus.wr_pattern = p;
    #2 chk("plain_ready", 64'(bus.wr_ready), 64'd1);
    @(negedge clock) bus.wr_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #2 write_check(i, p);
      @(negedge clock);
    end
    #2;
    chk("plain_done",      64'(bus.wr_done),   64'd1);
    chk("plain_done_busy", 64'(bus.busy),      64'd0);
    chk("plain_done_rdy",  64'(bus.wr_ready),  64'd0);
    chk("plain_done_we",   64'(bus.mem_write), 64'd0);
    @(negedge clock); #2;
    chk("plain_after_done", 64'(bus.wr_done),  64'd0);
    chk("plain_after_rdy",  64'(bus.wr_ready), 64'd1);

    // Contention: render takes the bus for 3 cycles at idx 5
    @(negedge clock);
    p = 20'h3C96F; bus.wr_valid = 1'b1; bus.wr_pattern = p;
    @(negedge clock) bus.wr_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #2 write_check(i, p);
      @(negedge clock);
    end
    bus.rd_req = 1'b1; bus.rd_x = 2'd2; bus.rd_y = 3'd3; bus.rd_char = 6'd0;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk($sformatf("stall%0d_we", k),   64'(bus.mem_write), 64'd0);
      chk($sformatf("stall%0d_x", k),    64'(bus.mem_x),     64'd2);
      chk($sformatf("stall%0d_y", k),    64'(bus.mem_y),     64'd3);
      chk($sformatf("stall%0d_busy", k), 64'(bus.busy),      64'd1);
      @(negedge clock);
    end
    bus.rd_req = 1'b0;
    for (int i = 5; i < 20; i++) begin
      #2 write_check(i, p);
      @(negedge clock);
    end
    #2 chk("contend_done", 64'(bus.wr_done), 64'd1);

    // Simultaneous accept with render, then reset at idx 7
    @(negedge clock);
    p = 20'hFFFFF; bus.wr_valid = 1'b1; bus.wr_pattern = p;
    bus.rd_req = 1'b1; bus.rd_x = 2'd1; bus.rd_y = 3'd1;
    #2 chk("simul_ready", 64'(bus.wr_ready), 64'd1);
    @(negedge clock) bus.wr_valid = 1'b0;
    #2;
    chk("simul_busy",  64'(bus.busy),      64'd1);
    chk("simul_we",    64'(bus.mem_write), 64'd0);
    chk("simul_mem_x", 64'(bus.mem_x),     64'd1);
    @(negedge clock) bus.rd_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #2 write_check(i, p);
      if (i < 7) @(negedge clock);
    end
    #1 rst = 1'b1;
    #1 idle_outputs_check("midrst");
    @(negedge clock) rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk($sformatf("postrst%0d_done", k), 64'(bus.wr_done), 64'd0);
      chk($sformatf("postrst%0d_busy", k), 64'(bus.busy),    64'd0);
      @(negedge clock);
    end

    // Back-to-back loads with wr_valid held high
    p = 20'h0F0F1; bus.wr_valid = 1'b1; bus.wr_pattern = p;
    @(negedge clock);
    for (int i = 0; i < 20; i++) begin
      #2 write_check(i, p);
      @(negedge clock);
    end
    #2;
    chk("b2b_done",       64'(bus.wr_done),  64'd1);
    chk("b2b_done_ready", 64'(bus.wr_ready), 64'd0);
    @(negedge clock);
    p = 20'h80001; bus.wr_pattern = p;
    #2;
    chk("b2b_idle_ready", 64'(bus.wr_ready), 64'd1);
    chk("b2b_idle_busy",  64'(bus.busy),     64'd0);
    chk("b2b_idle_done",  64'(bus.wr_done),  64'd0);
    @(negedge clock) bus.wr_valid = 1'b0;
    #2 write_check(0, p);
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clock); #2;
      n++;
      if (bus.wr_done) seen = 1'b1;
    end
    chk("b2b2_done_seen",   64'(seen), 64'd1);
    chk("b2b2_done_cycles", 64'(n),    64'd20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
